// File: rtl/fm_stream_reader_pkg.sv
// Shared widths, FSM state type and beat-width helper for the FM stream reader.
package fm_stream_reader_pkg;

    localparam int W_SIZE_D    = 8;
    localparam int W_CHANNEL_D = 6;
    localparam int FM_DW_D     = 32;
    localparam int FM_AW_D     = 12;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // One FIFO entry: data word, row tag, column tag, channel-tile tag, last flag.
    function automatic int beat_width(input int dw, input int ws, input int wc);
        return dw + 2 * ws + wc + 1;
    endfunction

endpackage

// File: rtl/fm_stream_reader_if.sv
// FM read port plus tagged output stream, seen from the reader (master) side.
interface fm_stream_reader_if #(
    parameter int W_SIZE    = 8,
    parameter int W_CHANNEL = 6,
    parameter int FM_DW     = 32,
    parameter int FM_AW     = 12
);
    logic                 o_fm_rd_en;
    logic [FM_AW-1:0]     o_fm_rd_addr;
    logic [FM_DW-1:0]     i_fm_rd_data;
    logic                 o_data_vld;
    logic                 i_ready;
    logic [FM_DW-1:0]     o_data;
    logic [W_SIZE-1:0]    o_row;
    logic [W_SIZE-1:0]    o_col;
    logic [W_CHANNEL-1:0] o_chn;
    logic                 o_last;

    modport master (
        output o_fm_rd_en, o_fm_rd_addr, o_data_vld, o_data, o_row, o_col, o_chn, o_last,
        input  i_fm_rd_data, i_ready
    );

    modport slave (
        input  o_fm_rd_en, o_fm_rd_addr, o_data_vld, o_data, o_row, o_col, o_chn, o_last,
        output i_fm_rd_data, i_ready
    );
endinterface

// File: rtl/fm_stream_reader_fifo.sv
// Two-entry synchronous FIFO holding returned FM words with their tags.
module fm_stream_fifo #(
    parameter int DW = 55
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [1:0]    o_count
);
    logic [DW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;
    logic          w_wr;
    logic          w_rd;

    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign w_wr = i_push && (!o_full || i_pop);
    assign w_rd = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) r_mem[i] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_rd) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + 2'(w_wr) - 2'(w_rd);
        end
    end
endmodule

// File: rtl/fm_stream_reader.sv
// Walks a stored feature map (channel tile, row, column) and streams each word with its tags.
//  state   | meaning
//  IDLE    | waiting for i_start; dimensions sampled on accept
//  RUN     | issuing reads under the FIFO credit limit
//  DRAIN   | all reads issued; waiting for the final beat to be accepted
//  DONE    | one-cycle completion pulse, then back to IDLE
module fm_stream_reader
    import fm_stream_reader_pkg::*;
#(
    parameter int W_SIZE    = W_SIZE_D,
    parameter int W_CHANNEL = W_CHANNEL_D,
    parameter int FM_DW     = FM_DW_D,
    parameter int FM_AW     = FM_AW_D
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_start,
    input  logic [W_SIZE-1:0]    q_width,
    input  logic [W_SIZE-1:0]    q_height,
    input  logic [W_CHANNEL-1:0] q_channel,
    output logic                 o_busy,
    output logic                 o_done,
    fm_stream_reader_if.master   bus
);
    localparam int BW = beat_width(FM_DW, W_SIZE, W_CHANNEL);

    state_t               r_state;
    logic                 r_busy;
    logic                 r_done;
    logic [W_SIZE-1:0]    r_q_w;
    logic [W_SIZE-1:0]    r_q_h;
    logic [W_CHANNEL-1:0] r_q_c;
    logic [W_SIZE-1:0]    r_col;
    logic [W_SIZE-1:0]    r_row;
    logic [W_CHANNEL-1:0] r_chn;
    logic [FM_AW-1:0]     r_addr;
    logic                 r_ret;
    logic [W_SIZE-1:0]    r_ret_row;
    logic [W_SIZE-1:0]    r_ret_col;
    logic [W_CHANNEL-1:0] r_ret_chn;
    logic                 r_ret_last;

    logic                 w_zero_dim;
    logic                 w_col_end;
    logic                 w_row_end;
    logic                 w_chn_end;
    logic                 w_pix_last;
    logic [W_CHANNEL-1:0] w_chn_nxt;
    logic [FM_AW-1:0]     w_step;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [1:0]           w_count;
    logic [2:0]           w_occ;
    logic                 w_issue;
    logic [BW-1:0]        w_push_beat;
    logic [BW-1:0]        w_head;

    assign w_zero_dim = (q_width == '0) || (q_height == '0) || (q_channel == '0);
    assign w_col_end  = (r_col == r_q_w - W_SIZE'(1));
    assign w_row_end  = (r_row == r_q_h - W_SIZE'(1));
    assign w_chn_end  = (r_chn == r_q_c - W_CHANNEL'(1));
    assign w_pix_last = w_col_end && w_row_end && w_chn_end;
    assign w_chn_nxt  = r_chn + W_CHANNEL'(1);
    assign w_step     = FM_AW'(r_q_c);

    // Entries that will exist once this cycle's read returns must fit in two slots.
    assign w_pop   = !w_empty && bus.i_ready;
    assign w_occ   = {1'b0, w_count} + {2'b00, r_ret} - {2'b00, w_pop};
    assign w_issue = (r_state == S_RUN) && (w_occ <= 3'd1) && !(w_full && !w_pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_busy <= 1'b1;
                        if (w_zero_dim) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue && w_pix_last) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // The last-tagged beat is the final word, so its pop empties the pipeline.
                    if (w_pop && bus.o_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q_w      <= '0;
            r_q_h      <= '0;
            r_q_c      <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_chn      <= '0;
            r_addr     <= '0;
            r_ret      <= 1'b0;
            r_ret_row  <= '0;
            r_ret_col  <= '0;
            r_ret_chn  <= '0;
            r_ret_last <= 1'b0;
        end else begin
            r_ret <= w_issue;
            if (r_state == S_IDLE && i_start) begin
                r_q_w  <= q_width;
                r_q_h  <= q_height;
                r_q_c  <= q_channel;
                r_col  <= '0;
                r_row  <= '0;
                r_chn  <= '0;
                r_addr <= '0;
            end else if (w_issue) begin
                r_ret_row  <= r_row;
                r_ret_col  <= r_col;
                r_ret_chn  <= r_chn;
                r_ret_last <= w_pix_last;
                if (!w_col_end) begin
                    r_col  <= r_col + W_SIZE'(1);
                    r_addr <= r_addr + w_step;
                end else begin
                    r_col <= '0;
                    if (!w_row_end) begin
                        r_row  <= r_row + W_SIZE'(1);
                        r_addr <= r_addr + w_step;
                    end else begin
                        // New channel tile restarts at its own base address.
                        r_row  <= '0;
                        r_chn  <= w_chn_nxt;
                        r_addr <= FM_AW'(w_chn_nxt);
                    end
                end
            end
        end
    end

    assign w_push_beat = {bus.i_fm_rd_data, r_ret_row, r_ret_col, r_ret_chn, r_ret_last};

    fm_stream_fifo #(.DW(BW)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (r_ret),
        .i_pop   (w_pop),
        .i_din   (w_push_beat),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign {bus.o_data, bus.o_row, bus.o_col, bus.o_chn, bus.o_last} = w_head;
    assign bus.o_data_vld   = !w_empty;
    assign bus.o_fm_rd_en   = w_issue;
    assign bus.o_fm_rd_addr = r_addr;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
endmodule
